// File: rtl/mux_pkg.sv
// Shared definitions for the parametrised round-robin / fixed-select output mux.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width for n entries, never less than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/mux_rr_pipe_rr_pick.sv
// Combinational rotating-priority picker: the first requesting channel at or after ptr wins.
module rr_pick
    import mux_pkg::*;
#(
    parameter  int N_CH  = 8,
    localparam int SEL_W = clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] grant,
    output logic             grant_valid
);

    int idx;

    // Scan from the farthest offset down so the nearest requester after ptr is written last.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            if (idx < N_CH && req[idx]) begin
                grant       = SEL_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_pipe.sv
// N-channel mux with registered output, valid/ready on both sides, fixed or round-robin select.
module mux_rr_pipe
    import mux_pkg::*;
#(
    parameter  int N_CH  = 8,
    parameter  int W     = 8,
    localparam int SEL_W = clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_valid,
    output logic [N_CH-1:0]   in_ready,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_ch,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [SEL_W-1:0] ptr;
    logic             load_en;

    logic [SEL_W-1:0] rr_grant;
    logic             rr_valid;
    logic             fix_valid;

    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic [W-1:0]     grant_data;
    logic             xfer;

    assign load_en = !out_valid || out_ready;

    rr_pick #(.N_CH(N_CH)) u_rr_pick (
        .req         (in_valid),
        .ptr         (ptr),
        .grant       (rr_grant),
        .grant_valid (rr_valid)
    );

    // Compare against every legal index so an out-of-range sel simply never matches.
    always_comb begin
        fix_valid = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == SEL_W'(k) && in_valid[k]) fix_valid = 1'b1;
        end
    end

    always_comb begin
        if (mode == MODE_RR) begin
            grant       = rr_grant;
            grant_valid = rr_valid;
        end else begin
            grant       = sel;
            grant_valid = fix_valid;
        end
    end

    always_comb begin
        grant_data = '0;
        in_ready   = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (grant == SEL_W'(k)) begin
                grant_data  = in_data[k*W +: W];
                in_ready[k] = grant_valid && load_en && !rst;
            end
        end
    end

    assign xfer = grant_valid && load_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else begin
            if (load_en) begin
                if (grant_valid) begin
                    out_data  <= grant_data;
                    out_ch    <= grant;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            if (xfer && mode == MODE_RR) begin
                ptr <= (grant == SEL_W'(N_CH - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_pipe.sv
// Directed bench for mux_rr_pipe with 8-, 6- and 5-channel instances.
module tb_mux_rr_pipe;
    import mux_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // 8-channel instance
    logic [63:0] d8;
    logic [7:0]  v8, rdy8, od8;
    logic [2:0]  s8, oc8;
    logic        m8, ov8, or8;

    mux_rr_pipe #(.N_CH(8), .W(8)) u8 (
        .clk(clk), .rst(rst), .in_data(d8), .in_valid(v8), .in_ready(rdy8),
        .mode(m8), .sel(s8), .out_data(od8), .out_ch(oc8), .out_valid(ov8),
        .out_ready(or8)
    );

    // 6-channel instance
    logic [47:0] d6;
    logic [5:0]  v6, rdy6;
    logic [7:0]  od6;
    logic [2:0]  s6, oc6;
    logic        m6, ov6, or6;

    mux_rr_pipe #(.N_CH(6), .W(8)) u6 (
        .clk(clk), .rst(rst), .in_data(d6), .in_valid(v6), .in_ready(rdy6),
        .mode(m6), .sel(s6), .out_data(od6), .out_ch(oc6), .out_valid(ov6),
        .out_ready(or6)
    );

    // 5-channel instance
    logic [39:0] d5;
    logic [4:0]  v5, rdy5;
    logic [7:0]  od5;
    logic [2:0]  s5, oc5;
    logic        m5, ov5, or5;

    mux_rr_pipe #(.N_CH(5), .W(8)) u5 (
        .clk(clk), .rst(rst), .in_data(d5), .in_valid(v5), .in_ready(rdy5),
        .mode(m5), .sel(s5), .out_data(od5), .out_ch(oc5), .out_valid(ov5),
        .out_ready(or5)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) d8[k*8 +: 8] = 8'hA0 + 8'(k);
        for (int k = 0; k < 6; k++) d6[k*8 +: 8] = 8'h60 + 8'(k);
        for (int k = 0; k < 5; k++) d5[k*8 +: 8] = 8'h50 + 8'(k);
        v8 = 8'hFF; m8 = MODE_RR;   s8 = 3'd0; or8 = 1'b1;
        v6 = 6'h00; m6 = MODE_FIXED; s6 = 3'd0; or6 = 1'b1;
        v5 = 5'h00; m5 = MODE_RR;   s5 = 3'd0; or5 = 1'b1;

        // Reset state, with inputs valid: in_ready held at zero while rst is high
        tick();
        #1;
        chk("rst_in_ready", 64'(rdy8), 64'h00);
        chk("rst_out_valid", 64'(ov8), 64'h0);
        chk("rst_out_data", 64'(od8), 64'h00);
        chk("rst_out_ch", 64'(oc8), 64'h0);

        // 1: all valid in round-robin, reset mid-stream
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rr_all_ch", 64'(oc8), 64'(c));
            chk("rr_all_data", 64'(od8), 64'(8'hA0 + 8'(c)));
        end
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(rdy8), 64'h00);
        tick();
        chk("midrst_out_valid", 64'(ov8), 64'h0);
        rst = 1'b0;
        tick();
        chk("post_rst_ch", 64'(oc8), 64'h0);
        chk("post_rst_data", 64'(od8), 64'hA0);
        chk("post_rst_valid", 64'(ov8), 64'h1);

        // 2: fixed select of ch5
        m8 = MODE_FIXED; s8 = 3'd5; v8 = 8'b0010_0000; d8[5*8 +: 8] = 8'h3C;
        #1;
        chk("fix_in_ready", 64'(rdy8), 64'h20);
        tick();
        chk("fix_out_data", 64'(od8), 64'h3C);
        chk("fix_out_ch", 64'(oc8), 64'h5);
        chk("fix_out_valid", 64'(ov8), 64'h1);

        // 5: backpressure holding 8'h11, then release with no bubble
        d8[5*8 +: 8] = 8'h11;
        tick();
        chk("bp_load", 64'(od8), 64'h11);
        or8 = 1'b0; d8[5*8 +: 8] = 8'h22; s8 = 3'd2; v8 = 8'b0010_0100;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_in_ready", 64'(rdy8), 64'h00);
            tick();
            chk("bp_hold_data", 64'(od8), 64'h11);
            chk("bp_hold_ch", 64'(oc8), 64'h5);
            chk("bp_hold_valid", 64'(ov8), 64'h1);
        end
        s8 = 3'd5;
        or8 = 1'b1;
        #1;
        chk("bp_release_ready", 64'(rdy8), 64'h20);
        tick();
        chk("bp_release_data", 64'(od8), 64'h22);
        chk("bp_release_valid", 64'(ov8), 64'h1);

        // 4: round-robin over sparse valid mask from ptr=0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m8 = MODE_RR; v8 = 8'b1010_0101;
        for (int k = 0; k < 8; k++) d8[k*8 +: 8] = 8'hA0 + 8'(k);
        begin
            logic [2:0] exp_seq [8];
            exp_seq = '{3'd0, 3'd2, 3'd5, 3'd7, 3'd0, 3'd2, 3'd5, 3'd7};
            for (int c = 0; c < 8; c++) begin
                tick();
                chk("rr_sparse_ch", 64'(oc8), 64'(exp_seq[c]));
            end
        end
        // Switching to fixed with an idle sel drains the output but keeps ptr (next rr grant ch0)
        m8 = MODE_FIXED; s8 = 3'd1;
        tick();
        chk("mode_sw_drain", 64'(ov8), 64'h0);
        m8 = MODE_RR;
        tick();
        chk("mode_sw_ptr_kept", 64'(oc8), 64'h0);

        // 3: out-of-range sel on 6 channels
        v6 = 6'h3F; m6 = MODE_FIXED; s6 = 3'd1;
        tick();
        chk("n6_load", 64'(od6), 64'h61);
        chk("n6_load_valid", 64'(ov6), 64'h1);
        s6 = 3'd7;
        #1;
        chk("n6_oor_ready", 64'(rdy6), 64'h00);
        tick();
        chk("n6_oor_drain", 64'(ov6), 64'h0);
        s6 = 3'd6;
        #1;
        chk("n6_oor6_ready", 64'(rdy6), 64'h00);
        tick();
        chk("n6_oor6_valid", 64'(ov6), 64'h0);

        // 6: pointer wrap on 5 channels with ch1 and ch4 valid
        v5 = 5'b10010;
        begin
            logic [2:0] exp5 [4];
            exp5 = '{3'd1, 3'd4, 3'd1, 3'd4};
            for (int c = 0; c < 4; c++) begin
                tick();
                chk("n5_wrap_ch", 64'(oc5), 64'(exp5[c]));
                chk("n5_wrap_data", 64'(od5), 64'(8'h50 + 8'(exp5[c])));
            end
        end
        // After a ch4 grant ptr must be 0: with ch0 and ch4 valid, ch0 wins
        v5 = 5'b10001;
        tick();
        chk("n5_ptr_zero", 64'(oc5), 64'h0);
        tick();
        chk("n5_after_zero", 64'(oc5), 64'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
